// File: rtl/uart_echo_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_echo_ctrl_if
//   Bundles the byte-level handshake between the UART receiver/transmitter
//   and the echo controller.
//
//   Signals:
//     rx_data              receiver -> ctrl  received byte
//     rx_complete_flag     receiver -> ctrl  byte-done level flag
//     rx_complete_del_flag ctrl -> receiver  clear request for the flag
//     tx_data              ctrl -> tx        byte to transmit
//     tx_start             ctrl -> tx        one-cycle transmit request
//     tx_busy              tx -> ctrl        transmitter busy for a frame
//
//   Modports:
//     master : UART side (receiver + transmitter)
//     slave  : echo controller
//
//   Handshake rules:
//     RX: rx_complete_flag is a level. The controller captures rx_data on the
//         first cycle it sees the flag high, then holds rx_complete_del_flag
//         high until it samples the flag low. No second capture happens while
//         the flag stays high.
//     TX: tx_start is a single-cycle request with tx_data valid in the same
//         cycle. The controller then waits for tx_busy to rise (frame
//         accepted) and fall (frame done) before issuing the next request.
// ---------------------------------------------------------------------------
interface uart_echo_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_complete_flag;
    logic       rx_complete_del_flag;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (
        output rx_data,
        output rx_complete_flag,
        input  rx_complete_del_flag,
        input  tx_data,
        input  tx_start,
        output tx_busy
    );

    modport slave (
        input  rx_data,
        input  rx_complete_flag,
        output rx_complete_del_flag,
        output tx_data,
        output tx_start,
        input  tx_busy
    );
endinterface

// File: rtl/uart_echo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_echo_ctrl
//   Echoes bytes received from a UART receiver back out through a UART
//   transmitter, buffering them in a FIFO_DEPTH-byte FIFO.
//
//   Optional feature (macro ECHO_CASE_SWAP_EN):
//     defined   : lower-case ASCII 0x61..0x7A is upper-cased before buffering
//     undefined : bytes are echoed verbatim
//
//   Parameters:
//     FIFO_DEPTH  echo buffer depth in bytes, power of two, 2..64
//
//   Ports:
//     clk             system clock, rising edge
//     reset_n         asynchronous active-low reset
//     uart            handshake bundle (slave modport), see uart_echo_ctrl_if
//     echo_enable     1 = queue received bytes, 0 = discard them
//     ovf_clr         synchronous clear of overflow
//     overflow        sticky: a byte was dropped because the FIFO was full
//     fifo_count      bytes currently buffered
//     dbg_rx_state_o  RX FSM state (0 RX_IDLE, 1 RX_CLEAR)
//     dbg_tx_state_o  TX FSM state (0 TX_IDLE, 1 TX_WAIT_ACK, 2 TX_WAIT_DONE)
//
//   Latency: flag sampled high at edge k -> capture at k, push at k+1,
//   pop and tx_start registered at k+2, so tx_start is seen high at k+3.
// ---------------------------------------------------------------------------
module uart_echo_ctrl #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    uart_echo_ctrl_if.slave               uart,
    input  logic                          echo_enable,
    input  logic                          ovf_clr,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          dbg_rx_state_o,
    output logic [1:0]                    dbg_tx_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_CLEAR = 1'b1
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_ACK  = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

    rx_state_e rx_state_q, rx_state_d;
    tx_state_e tx_state_q, tx_state_d;

    logic [7:0]    cap_q, cap_d;
    logic          push_q, push_d;
    logic [7:0]    rx_byte;
    logic          capture;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    logic          ovf_q, ovf_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;

    // ------------------------------------------------------------------
    // Byte conversion ahead of capture
    // ------------------------------------------------------------------
`ifdef ECHO_CASE_SWAP_EN
    always_comb begin
        rx_byte = uart.rx_data;
        if (uart.rx_data >= 8'h61 && uart.rx_data <= 8'h7A) begin
            rx_byte[5] = 1'b0;
        end
    end
`else
    assign rx_byte = uart.rx_data;
`endif

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    always_comb begin
        rx_state_d = rx_state_q;
        capture    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (uart.rx_complete_flag) begin
                    capture    = 1'b1;
                    rx_state_d = RX_CLEAR;
                end
            end
            RX_CLEAR: begin
                if (!uart.rx_complete_flag) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        cap_d  = capture ? rx_byte : cap_q;
        // Disabled echo still runs the clear handshake, it just never pushes.
        push_d = capture & echo_enable;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            cap_q      <= 8'h00;
            push_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cap_q      <= cap_d;
            push_q     <= push_d;
        end
    end

    // The clear request is exactly "in RX_CLEAR", which is already a flop.
    assign uart.rx_complete_del_flag = (rx_state_q == RX_CLEAR);

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    assign full    = (count_q == CW'(FIFO_DEPTH));
    // A same-cycle pop frees a slot, so a push into a full FIFO is accepted.
    assign push_ok = push_q & (~full | pop);
    assign drop    = push_q & full & ~pop;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= cap_q;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    always_comb begin
        tx_state_d = tx_state_q;
        pop        = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (count_q != '0 && !uart.tx_busy) begin
                    pop        = 1'b1;
                    tx_state_d = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK: begin
                if (uart.tx_busy) begin
                    tx_state_d = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!uart.tx_busy) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        tx_start_d = pop;
        // tx_data holds the last popped byte until the next pop.
        tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign uart.tx_data  = tx_data_q;
    assign uart.tx_start = tx_start_q;
    assign overflow      = ovf_q;
    assign fifo_count    = count_q;
    assign dbg_rx_state_o = rx_state_q;
    assign dbg_tx_state_o = tx_state_q;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_ctrl
//   Directed bench for uart_echo_ctrl with FIFO_DEPTH = 8. A small receiver
//   model drives the flag/clear handshake, a transmitter model answers
//   tx_start with a few busy cycles (or holds busy high on request) and
//   records every transmitted byte for comparison against exp_q.
// ---------------------------------------------------------------------------
module tb_uart_echo_ctrl;

    localparam int DEPTH = 8;

    logic       clk;
    logic       reset_n;
    logic       echo_enable;
    logic       ovf_clr;
    logic       overflow;
    logic [3:0] fifo_count;
    logic       dbg_rx;
    logic [1:0] dbg_tx;

    uart_echo_ctrl_if u_if ();

    uart_echo_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .uart           (u_if.slave),
        .echo_enable    (echo_enable),
        .ovf_clr        (ovf_clr),
        .overflow       (overflow),
        .fifo_count     (fifo_count),
        .dbg_rx_state_o (dbg_rx),
        .dbg_tx_state_o (dbg_tx)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check({tag, "_byte"}, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- transmitter model ----------------
    int   busy_cnt  = 0;
    logic hold_busy = 1'b0;

    always @(negedge clk) begin
        if (u_if.tx_start) begin
            got_q.push_back(u_if.tx_data);
            busy_cnt = 4;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        u_if.tx_busy = hold_busy || (busy_cnt > 0);
    end

    // ---------------- receiver driver ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        u_if.rx_data          = b;
        u_if.rx_complete_flag = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u_if.rx_complete_del_flag && n < 10);
        check("del_raise", u_if.rx_complete_del_flag, 1'b1);
        u_if.rx_complete_flag = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (u_if.rx_complete_del_flag && n < 10);
        check("del_drop", u_if.rx_complete_del_flag, 1'b0);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (!(fifo_count == 0 && dbg_tx == 2'd0 && !u_if.tx_busy) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (fifo_count == 0 && dbg_tx == 2'd0 && !u_if.tx_busy), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_del"},      u_if.rx_complete_del_flag, 1'b0);
        check({tag, "_tx_start"}, u_if.tx_start, 1'b0);
        check({tag, "_tx_data"},  u_if.tx_data, 8'h00);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_count"},    fifo_count, 4'd0);
        check({tag, "_rx_state"}, dbg_rx, 1'b0);
        check({tag, "_tx_state"}, dbg_tx, 2'd0);
    endtask

    logic [7:0] swap_in  [4];
    logic [7:0] swap_exp [4];

    // ---------------- main sequence ----------------
    initial begin
        reset_n               = 1'b1;
        echo_enable           = 1'b1;
        ovf_clr               = 1'b0;
        u_if.rx_data          = 8'h00;
        u_if.rx_complete_flag = 1'b0;
        u_if.tx_busy          = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- single byte 0x55, cycle-exact latency ----
        u_if.rx_data          = 8'h55;
        u_if.rx_complete_flag = 1'b1;
        check("lat_del_before", u_if.rx_complete_del_flag, 1'b0);
        @(posedge clk); #1;                       // capture edge
        check("lat_del_e0", u_if.rx_complete_del_flag, 1'b1);
        check("lat_start_e0", u_if.tx_start, 1'b0);
        @(negedge clk);
        u_if.rx_complete_flag = 1'b0;
        @(posedge clk); #1;                       // push edge
        check("lat_del_e1", u_if.rx_complete_del_flag, 1'b0);
        check("lat_count_e1", fifo_count, 4'd1);
        check("lat_start_e1", u_if.tx_start, 1'b0);
        @(posedge clk); #1;                       // pop edge
        check("lat_start_e2", u_if.tx_start, 1'b1);
        check("lat_data_e2", u_if.tx_data, 8'h55);
        check("lat_count_e2", fifo_count, 4'd0);
        @(posedge clk); #1;
        check("lat_start_e3", u_if.tx_start, 1'b0);
        check("lat_data_hold", u_if.tx_data, 8'h55);
        exp_q.push_back(8'h55);
        wait_idle(50);
        cmp_stream("single");

        // ---- nine bytes into a held-busy transmitter ----
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        check("fill_count8", fifo_count, 4'd8);
        check("fill_ovf_pre", overflow, 1'b0);
        send_byte(8'h09);
        check("fill_count_after9", fifo_count, 4'd8);
        check("fill_ovf_set", overflow, 1'b1);

        // plain clear
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // drop coinciding with clear: drop wins
        @(negedge clk);
        u_if.rx_data          = 8'h0A;
        u_if.rx_complete_flag = 1'b1;
        @(negedge clk);                           // after capture edge
        u_if.rx_complete_flag = 1'b0;
        ovf_clr               = 1'b1;
        @(negedge clk);                           // after push/drop edge
        ovf_clr = 1'b0;
        check("ovf_drop_wins", overflow, 1'b1);
        check("ovf_drop_count", fifo_count, 4'd8);
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        check("ovf_cleared2", overflow, 1'b0);
        check("fill_no_tx", got_q.size(), 0);

        hold_busy = 1'b0;
        wait_idle(400);
        cmp_stream("fill");

        // ---- echo disabled ----
        echo_enable = 1'b0;
        send_byte(8'hA5);
        repeat (6) @(negedge clk);
        check("dis_count", fifo_count, 4'd0);
        check("dis_ovf", overflow, 1'b0);
        check("dis_no_tx", got_q.size(), 0);
        echo_enable = 1'b1;

        // ---- case conversion table ----
        swap_in[0] = 8'h61; swap_in[1] = 8'h7A; swap_in[2] = 8'h41; swap_in[3] = 8'h7B;
`ifdef ECHO_CASE_SWAP_EN
        swap_exp[0] = 8'h41; swap_exp[1] = 8'h5A; swap_exp[2] = 8'h41; swap_exp[3] = 8'h7B;
`else
        swap_exp[0] = 8'h61; swap_exp[1] = 8'h7A; swap_exp[2] = 8'h41; swap_exp[3] = 8'h7B;
`endif
        for (int i = 0; i < 4; i++) begin
            send_byte(swap_in[i]);
            exp_q.push_back(swap_exp[i]);
        end
        wait_idle(200);
        cmp_stream("swap");

        // ---- reset while in TX_WAIT_DONE with 3 bytes buffered ----
        send_byte(8'h10);
        exp_q.push_back(8'h10);
        begin
            int n;
            n = 0;
            while (got_q.size() == 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        hold_busy = 1'b1;
        cmp_stream("pre_rst");
        send_byte(8'h11);
        send_byte(8'h12);
        send_byte(8'h13);
        check("rst_pre_state", dbg_tx, 2'd2);
        check("rst_pre_count", fifo_count, 4'd3);
        @(negedge clk);
        reset_n   = 1'b0;
        hold_busy = 1'b0;
        busy_cnt  = 0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        got_q.delete();
        send_byte(8'h33);
        exp_q.push_back(8'h33);
        wait_idle(100);
        cmp_stream("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_echo_ctrl.md
UART_ECHO_CTRL -- requirements
Module: uart_echo_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, echo buffer depth in bytes; power of two, 2..64.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8  received byte from the 16x-oversampling UART receiver.
REQ-005 rx_complete_flag  input  1  receiver byte-done flag; level, held high until cleared.
REQ-006 rx_complete_del_flag  output  1  clear request to the receiver.
REQ-007 tx_data  output  8  byte to the UART transmitter.
REQ-008 tx_start  output  1  one-cycle transmit request.
REQ-009 tx_busy  input  1  transmitter busy, high for the duration of a frame.
REQ-010 echo_enable  input  1  1 = received bytes are queued for echo; 0 = they are discarded.
REQ-011 ovf_clr  input  1  synchronous clear of overflow.
REQ-012 overflow  output  1  sticky: a byte was dropped because the buffer was full.
REQ-013 fifo_count  output  clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-014 RX FSM states SHALL be RX_IDLE, RX_CLEAR.
- RX_IDLE, rx_complete_flag=1: capture rx_data that same cycle, go to RX_CLEAR.
- RX_CLEAR: hold rx_complete_del_flag=1 (registered, first high the cycle after capture); return to RX_IDLE, with del=0, on the first cycle rx_complete_flag is sampled 0.
REQ-015 One byte per rx_complete_flag assertion; a flag still high in RX_CLEAR SHALL NOT cause a second capture.
REQ-016 Captured byte SHALL be pushed into the FIFO one cycle after capture when echo_enable=1 at capture; with echo_enable=0 it is dropped, still cleared, and overflow is unaffected.
REQ-017 Push while full SHALL drop the byte, leave contents unchanged and set overflow the next cycle.
REQ-018 overflow SHALL clear on ovf_clr=1; a drop in the same cycle as ovf_clr wins (overflow stays 1).
REQ-019 TX FSM states SHALL be TX_IDLE, TX_WAIT_ACK, TX_WAIT_DONE.
- TX_IDLE, fifo non-empty and tx_busy=0: pop the head, drive tx_data, pulse tx_start for exactly one cycle, go to TX_WAIT_ACK.
- TX_WAIT_ACK: go to TX_WAIT_DONE when tx_busy=1.
- TX_WAIT_DONE: go to TX_IDLE when tx_busy=0.
REQ-020 tx_data SHALL stay stable from tx_start until the next pop.
REQ-021 Bytes SHALL be transmitted in FIFO order with no loss or duplication.
REQ-022 Simultaneous push and pop SHALL leave fifo_count unchanged and be legal when full or empty.
  - Push into a full FIFO with a same-cycle pop is accepted.
  - Pop from an empty FIFO is never issued.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 Minimum latency SHALL be 3 cycles, from rx_complete_flag sampled high to tx_start high, on an empty FIFO with tx_busy=0.

Reset
REQ-025 On reset_n=0, asynchronously:
- FSMs go to RX_IDLE/TX_IDLE.
- Pointers and fifo_count go to 0.
- rx_complete_del_flag=0, tx_start=0, tx_data=0, overflow=0.
REQ-026 Reset mid-frame SHALL discard buffered bytes; the first post-reset byte is handled normally.

Configuration
REQ-027 Macro ECHO_CASE_SWAP_EN.
- Defined: bytes 0x61..0x7A are converted to 0x41..0x5A (bit 5 cleared) before push; other bytes are unchanged.
- Undefined: bytes are echoed verbatim and no conversion logic exists.

Verification
REQ-028 Single byte 0x55, echo_enable=1, tx_busy idle:
- del high the cycle after capture until flag drops.
- tx_start pulses once with tx_data=0x55 three cycles after the flag.
REQ-029 Nine bytes 0x01..0x09 sent while tx_busy is held 1, FIFO_DEPTH=8:
- fifo_count=8 and overflow=1.
- After release, the bytes transmitted are 0x01..0x08 in order.
REQ-030 echo_enable=0, byte 0xA5 -> flag cleared via del, fifo_count stays 0, no tx_start.
REQ-031 Byte 0x61 -> tx_data=0x41 with ECHO_CASE_SWAP_EN, 0x61 without.
REQ-032 reset_n pulsed low with 3 bytes buffered during TX_WAIT_DONE:
- All outputs return to their reset values.
- Next byte 0x33 is echoed alone.
